// File: rtl/keypad_scan_fifo_if.sv
// Event handshake between the keypad scanner (master) and the command decoder (slave).
interface keypad_scan_fifo_if #(
  parameter int unsigned KW = 4
);
  logic          ev_valid;
  logic          ev_ready;
  logic [KW-1:0] ev_code;
  logic          ev_press;

  modport master (
    output ev_valid,
    output ev_code,
    output ev_press,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_code,
    input  ev_press,
    output ev_ready
  );
endinterface

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: rotating active-low rows, per-key debounce and a show-ahead
// press/release event FIFO with valid/ready handshake.
module keypad_scan_fifo #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned FIFO_DEPTH     = 4,
  localparam int unsigned NK            = ROWS * COLS,
  localparam int unsigned KW            = $clog2(NK),
  localparam int unsigned CW            = $clog2(NK + 1)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ROWS-1:0]    row_n,
  input  logic [COLS-1:0]    col_n,
  keypad_scan_fifo_if.master ev,
  output logic [CW-1:0]      key_count,
  output logic               overflow
);

  localparam int unsigned DW  = $clog2(SCAN_DIV);
  localparam int unsigned RW  = $clog2(ROWS);
  localparam int unsigned CIW = $clog2(COLS);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);

  localparam logic [DW-1:0] DivLast = DW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);
  localparam logic [3:0]    DebLast = 4'(DEBOUNCE_SCANS);

  typedef struct packed {
    logic [KW-1:0] code;
    logic          press;
  } event_t;

  // Column synchronizer; stage 1 stores the inverted level so 1 = contact.
  logic [COLS-1:0] col_s1_q, col_s2_q;

  logic [DW-1:0]   div_q, div_d;
  logic [RW-1:0]   row_q, row_d;
  logic [ROWS-1:0] row_n_q, row_n_d;
  logic [COLS-1:0] samp_q, samp_d;
  logic [RW-1:0]   samp_row_q, samp_row_d;

  logic [NK-1:0]   stable_q;
  logic [3:0]      cnt_q [NK];

  logic            eval_en;
  logic [CIW-1:0]  eval_col;
  logic [KW-1:0]   eval_key;
  logic            eval_raw;
  logic            eval_stable;
  logic [3:0]      eval_cnt_inc;
  logic [3:0]      eval_cnt_d;
  logic            eval_flip;

  event_t          cand_q, cand_d;
  logic            cand_valid_q, cand_valid_d;
  logic [CW-1:0]   key_count_q, key_count_d;

  event_t          mem_q [FIFO_DEPTH];
  logic [PW:0]     wr_ptr_q, rd_ptr_q;
  logic            fifo_empty, fifo_full;
  logic            push, pop, wr_en;
  logic            overflow_q, overflow_d;

  // Row rotation and sample latch.
  always_comb begin
    div_d      = (div_q == DivLast) ? '0 : div_q + DW'(1);
    row_d      = row_q;
    samp_d     = samp_q;
    samp_row_d = samp_row_q;
    if (div_q == DivLast) begin
      row_d      = (row_q == RowLast) ? '0 : row_q + RW'(1);
      samp_d     = col_s2_q;
      samp_row_d = row_q;
    end
    row_n_d = ~(ROWS'(1) << row_d);
  end

  // Serial evaluation of the latched sample, one column per divider step.
  always_comb begin
    eval_en      = (div_q < DW'(COLS));
    eval_col     = div_q[CIW-1:0];
    eval_key     = KW'(int'(samp_row_q) * COLS + int'(eval_col));
    eval_raw     = samp_q[eval_col];
    eval_stable  = stable_q[eval_key];
    eval_cnt_inc = cnt_q[eval_key] + 4'd1;
    eval_flip    = 1'b0;
    eval_cnt_d   = '0;
    if (eval_raw != eval_stable) begin
      if (eval_cnt_inc == DebLast) begin
        eval_flip = 1'b1;
      end else begin
        eval_cnt_d = eval_cnt_inc;
      end
    end

    cand_valid_d = eval_en && eval_flip;
    cand_d.code  = eval_key;
    cand_d.press = ~eval_stable;

    key_count_d = key_count_q;
    if (eval_en && eval_flip) begin
      key_count_d = eval_stable ? key_count_q - CW'(1) : key_count_q + CW'(1);
    end
  end

  // Event FIFO; a push while full survives only if the head leaves in the same cycle.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    pop        = !fifo_empty && ev.ev_ready;
    push       = cand_valid_q;
    wr_en      = push && (!fifo_full || pop);
    overflow_d = overflow_q || (push && fifo_full && !pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1_q     <= '0;
      col_s2_q     <= '0;
      div_q        <= '0;
      row_q        <= '0;
      row_n_q      <= '1;
      samp_q       <= '0;
      samp_row_q   <= '0;
      stable_q     <= '0;
      for (int i = 0; i < NK; i++) begin
        cnt_q[i] <= '0;
      end
      cand_q       <= '0;
      cand_valid_q <= 1'b0;
      key_count_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      col_s1_q     <= ~col_n;
      col_s2_q     <= col_s1_q;
      div_q        <= div_d;
      row_q        <= row_d;
      row_n_q      <= row_n_d;
      samp_q       <= samp_d;
      samp_row_q   <= samp_row_d;
      if (eval_en) begin
        cnt_q[eval_key] <= eval_cnt_d;
        if (eval_flip) begin
          stable_q[eval_key] <= ~eval_stable;
        end
      end
      cand_q       <= cand_d;
      cand_valid_q <= cand_valid_d;
      key_count_q  <= key_count_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      end
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[PW-1:0]] <= cand_q;
    end
  end

  assign row_n       = row_n_q;
  assign key_count   = key_count_q;
  assign overflow    = overflow_q;
  assign ev.ev_valid = !fifo_empty;
  assign ev.ev_code  = mem_q[rd_ptr_q[PW-1:0]].code;
  assign ev.ev_press = mem_q[rd_ptr_q[PW-1:0]].press;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Scoreboard bench for keypad_scan_fifo: key changes land on scan boundaries, a per-scan
// debounce model predicts events, and a negedge monitor checks the handshake output.
module tb_keypad_scan_fifo;
  localparam int unsigned ROWS     = 4;
  localparam int unsigned COLS     = 4;
  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned DEB      = 3;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned NK       = ROWS * COLS;
  localparam int unsigned KW       = 4;
  localparam int unsigned CW       = 5;
  localparam int unsigned T        = ROWS * SCAN_DIV;

  typedef struct packed {
    logic [KW-1:0] code;
    logic          press;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_n;
  logic [CW-1:0]   key_count;
  logic            overflow;
  logic [NK-1:0]   keys = '0;
  logic            ready_fix = 1'b1;
  logic            rnd_ready = 1'b0;
  logic            rnd_bit = 1'b1;

  int  vectors = 0;
  int  errors  = 0;
  ev_t sb[$];

  bit  m_stable [NK];
  int  m_run [NK];
  int  m_count;
  bit  m_ovf;
  bit  stalled = 1'b0;

  keypad_scan_fifo_if #(.KW(KW)) bus ();
  assign bus.ev_ready = rnd_ready ? rnd_bit : ready_fix;

  keypad_scan_fifo #(
    .ROWS          (ROWS),
    .COLS          (COLS),
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .ev       (bus),
    .key_count(key_count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Passive switch matrix: a closed key pulls its column low while its row is driven low.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!row_n[r] && keys[r*COLS+c]) col_n[c] = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NK-1:0] kbit(input int i);
    logic [NK-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NK; i++) begin
      m_stable[i] = 1'b0;
      m_run[i]    = 0;
    end
    m_count = 0;
    m_ovf   = 1'b0;
    sb.delete();
  endtask

  // One full scan: a key flips after DEB consecutive scans disagreeing with its stable level.
  task automatic model_scan(input logic [NK-1:0] k);
    for (int i = 0; i < NK; i++) begin
      if (k[i] == m_stable[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_run[i]    = 0;
          m_stable[i] = k[i];
          m_count     = m_count + (k[i] ? 1 : -1);
          if (stalled && sb.size() >= DEPTH) m_ovf = 1'b1;
          else sb.push_back('{code: KW'(i), press: k[i]});
        end
      end
    end
  endtask

  // Entered 1 time unit after a scan-start edge; returns at the next scan-start edge.
  task automatic do_scan(input logic [NK-1:0] k);
    int exp_cnt;
    bit exp_ovf;
    exp_cnt = m_count;
    exp_ovf = m_ovf;
    keys    = k;
    model_scan(k);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("key_count", int'(key_count), exp_cnt);
    check("overflow", int'(overflow), int'(exp_ovf));
    repeat (26) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("row_n in reset", int'(row_n), 15);
    check("ev_valid after reset", int'(bus.ev_valid), 0);
    check("key_count after reset", int'(key_count), 0);
    check("overflow after reset", int'(overflow), 0);
  endtask

  // Monitor: pops the scoreboard on every accepted event and checks head stability on stalls.
  initial begin
    ev_t       e;
    bit        hold_pending;
    logic [KW-1:0] held_code;
    logic      held_press;
    hold_pending = 1'b0;
    held_code    = '0;
    held_press   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending && bus.ev_valid) begin
          check("ev_code held", int'(bus.ev_code), int'(held_code));
          check("ev_press held", int'(bus.ev_press), int'(held_press));
        end
        if (bus.ev_valid && bus.ev_ready) begin
          if (sb.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected event: code %0d press %0d, expected none (t=%0t)",
                     bus.ev_code, bus.ev_press, $time);
          end else begin
            e = sb.pop_front();
            check("ev_code", int'(bus.ev_code), int'(e.code));
            check("ev_press", int'(bus.ev_press), int'(e.press));
          end
        end
        hold_pending = bus.ev_valid && !bus.ev_ready;
        held_code    = bus.ev_code;
        held_press   = bus.ev_press;
      end
    end
  end

  initial begin
    logic [ROWS-1:0] exp_row;
    logic [NK-1:0]   cur;

    do_reset(3);
    for (int n = 1; n <= 2 * T; n++) begin
      @(posedge clk);
      #1;
      exp_row = ~(ROWS'(1) << ((n / SCAN_DIV) % ROWS));
      check("row_n rotation", int'(row_n), int'(exp_row));
    end

    // Single press and release of key 9.
    repeat (6) do_scan(kbit(9));
    repeat (4) do_scan('0);

    // Key 5 bounces for four scans, then is held.
    do_scan(kbit(5));
    do_scan('0);
    do_scan(kbit(5));
    do_scan('0);
    repeat (5) do_scan(kbit(5));
    repeat (4) do_scan('0);

    // Simultaneous keys 0, 7, 15.
    repeat (4) do_scan(kbit(0) | kbit(7) | kbit(15));
    repeat (4) do_scan('0);
    repeat (2) do_scan('0);

    // Backpressure: six events into a four-deep FIFO.
    ready_fix = 1'b0;
    stalled   = 1'b1;
    repeat (4) do_scan(kbit(1) | kbit(2) | kbit(4));
    repeat (5) do_scan('0);
    check("ev_valid while stalled", int'(bus.ev_valid), 1);
    ready_fix = 1'b1;
    stalled   = 1'b0;
    repeat (2) do_scan('0);
    check("scoreboard drained after overflow", sb.size(), 0);

    // Reset with two events queued while key 3 stays held.
    ready_fix = 1'b0;
    stalled   = 1'b1;
    repeat (4) do_scan(kbit(3) | kbit(10));
    check("ev_valid before reset", int'(bus.ev_valid), 1);
    stalled   = 1'b0;
    ready_fix = 1'b1;
    do_reset(1);
    repeat (6) do_scan(kbit(3));
    repeat (4) do_scan('0);

    // Random key activity.
    cur = '0;
    for (int s = 0; s < 30; s++) begin
      for (int i = 0; i < NK; i++) begin
        if ($urandom_range(0, 7) == 0) cur[i] = ~cur[i];
      end
      do_scan(cur);
    end
    repeat (4) do_scan('0);

    // Random ready with sparse events on key 12.
    rnd_ready = 1'b1;
    cur = '0;
    for (int s = 0; s < 16; s++) begin
      if (s % 4 == 0) cur = cur ^ kbit(12);
      do_scan(cur);
    end
    rnd_ready = 1'b0;
    repeat (5) do_scan('0);
    check("scoreboard drained at end", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_fifo.md
# keypad_scan_fifo

Parametrised matrix-keypad scanner: the successor to the fixed 4x4 scanner in the front-panel path.
- Drives ROWS active-low row lines in rotation and samples COLS active-low column lines.
- Debounces every key independently, so multi-key presses are supported and scanning never freezes on a held key.
- Queues press and release events in a small FIFO with a valid/ready handshake toward the command decoder.

## Interface
- ROWS, 4, number of row lines (2..8)
- COLS, 4, number of column lines (2..8)
- SCAN_DIV, 1000, clock cycles each row is driven; must be >= COLS+4
- DEBOUNCE_SCANS, 3, consecutive full scans a key's raw level must differ from its stable level before it flips (1..15)
- FIFO_DEPTH, 4, event FIFO entries (power of two, >= 2)
- Derived: KW = clog2(ROWS*COLS); CW = clog2(ROWS*COLS+1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- row_n  out  ROWS  row drive; exactly one bit low outside reset
- col_n  in  COLS  column sense, active low, asynchronous
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts the head event
- ev_code  out  KW  key index = row*COLS + col
- ev_press  out  1  1 = press, 0 = release
- key_count  out  CW  number of keys currently in the stable-pressed state
- overflow  out  1  sticky; an event was dropped because the FIFO was full

## Operation
- **Column sync:** each col_n bit passes through a 2-FF synchronizer and is inverted (1 = contact).
- **Row rotation:**
  - A divider counts 0..SCAN_DIV-1. At wrap, the row index advances 0,1,..,ROWS-1,0.
  - row_n = ~(1 << row index).
- **Sampling:**
  - On the cycle where the divider equals SCAN_DIV-1, the synchronized columns are latched into samp[COLS-1:0] together with samp_row = current row index.
  - The latched sample is evaluated serially, one column per cycle, on divider values 0..COLS-1 of the following dwell.
  - This gives at most one candidate event per cycle.
- **Per-key debounce:** each of the ROWS*COLS keys holds a stable bit and a 4-bit counter.
  - If raw == stable, the counter clears.
  - Otherwise the counter increments. When the incremented value reaches DEBOUNCE_SCANS, the stable bit flips, the counter clears, and an event {code, press = new stable} is pushed.
- **key_count:** +1 on every press flip and -1 on every release flip.
- **FIFO:** show-ahead.
  - ev_valid = not empty; ev_code and ev_press show the head entry.
  - A pop happens when ev_valid && ev_ready.
  - A push while full is accepted only if a pop happens in the same cycle. Otherwise the event is dropped and overflow is set.
  - A dropped event still flips the stable bit and updates key_count.
  - Simultaneous push and pop when empty: the push is stored and ev_valid rises next cycle.
- **Outputs:** ev_code and ev_press are stable while ev_valid && !ev_ready.

## Timing
- **Reset (rst high at a clk edge):**
  - row_n = all ones; divider = 0; row index = 0.
  - All stable bits and counters = 0; samp = 0.
  - FIFO empty; ev_valid = 0; key_count = 0; overflow = 0; synchronizers cleared.
- **After reset:** on the first cycle after rst falls, row_n = ~1.
- **Reset mid-scan or with the FIFO non-empty:** all state is discarded. Keys held through reset re-debounce from zero and generate fresh press events.
- **Scan period:** T = ROWS*SCAN_DIV cycles.
- **Press latency:** a contact stable from before row r's sample point produces its push DEBOUNCE_SCANS scans later, on divider cycle col+1 after that scan's sample. ev_valid asserts one cycle after the push (empty FIFO).
- **Bounce:** any sample agreeing with stable before the count completes restarts debounce.
- **Ghosting:** ghost keys on 3-key rectangles are not suppressed; they are reported as seen.

## Test plan
Parameters: ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE_SCANS=3, FIFO_DEPTH=4, ev_ready=1 unless stated.

- **Reset/rotation:** release rst, no keys pressed.
  - row_n = 1110,1101,1011,0111 repeating, each for 8 cycles.
  - ev_valid stays 0; key_count = 0.
- **Single press/release:** short row 2 to column 1 (key 9) for 6 scans, then release.
  - Exactly one event {9, press} is generated, then one {9, release}.
  - key_count goes 0 -> 1 -> 0.
- **Bounce:** key 5 toggles every scan for 4 scans, then is held.
  - No event during toggling.
  - {5, press} arrives exactly 3 scans after the hold begins.
- **Multi-key:** keys 0, 7 and 15 are pressed in the same scan.
  - Three press events in scan order 0, 7, 15.
  - key_count = 3.
- **Backpressure/overflow:** ev_ready = 0; press and release 3 distinct keys (6 events).
  - The first 4 events are queued and overflow = 1.
  - With ev_ready = 1 again, exactly 4 events drain in order and key_count = 0.
  - overflow stays 1 until rst.
- **Reset mid-operation:** hold key 3, assert rst for 1 cycle with 2 events queued.
  - The FIFO empties and key_count = 0.
  - {3, press} reappears 3 scans later.
